// File: rtl/dmem_pkg.sv
// Shared encodings, FSM state type and lane helpers for the data-memory access path.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  localparam int unsigned TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {StIdle, StBus, StResp} dmem_state_e;

  function automatic logic [3:0] byte_enable(logic [1:0] size, logic [1:0] off);
    case (size)
      SZ_BYTE: return 4'b0001 << off;
      SZ_HALF: return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic is_misaligned(logic [1:0] size, logic [1:0] off);
    return ((size == SZ_HALF) && off[0]) || ((size == SZ_WORD) && (off != 2'b00));
  endfunction

  // Replicate store data across lanes so byte enables alone pick the target bytes.
  function automatic logic [31:0] lane_wdata(logic [1:0] size, logic [31:0] wdata);
    case (size)
      SZ_BYTE: return {4{wdata[7:0]}};
      SZ_HALF: return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Ready/valid data-memory bus; the controller is the master, the memory the slave.
interface dmem_access_ctrl_if;

  logic        mem_valid;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ready, mem_rdata
  );

endinterface

// File: rtl/dmem_lane_align.sv
// Combinational load-data extraction: shift the addressed lane down, then sign/zero extend.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  assign shifted = rdata_i >> {off_i, 3'b000};

  always_comb begin
    data_o = shifted;
    case (size_i)
      SZ_BYTE: data_o = {{24{~unsigned_i & shifted[7]}}, shifted[7:0]};
      SZ_HALF: data_o = {{16{~unsigned_i & shifted[15]}}, shifted[15:0]};
      default: data_o = shifted;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Load/store sequencer: checks alignment, runs one bus transaction with timeout,
// returns extended load data and stalls the core until the access completes.
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid_i,
  input  logic                req_we_i,
  input  logic [1:0]          req_size_i,
  input  logic                req_unsigned_i,
  input  logic [31:0]         req_addr_i,
  input  logic [31:0]         req_wdata_i,
  output logic                stall_o,
  output logic                done_o,
  output logic                fault_o,
  output logic [31:0]         rdata_o,
  dmem_access_ctrl_if.master  mem
);

  localparam logic [7:0] LastWait = 8'(TIMEOUT - 1);

  dmem_state_e state_q;
  logic [7:0]  wait_q;
  logic        mem_valid_q;
  logic        mem_we_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [1:0]  off_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic        done_q;
  logic        fault_q;
  logic [31:0] rdata_q;
  logic [31:0] load_data;
  logic        req_bad;

  assign req_bad = (req_size_i == SZ_ILLEGAL) || is_misaligned(req_size_i, req_addr_i[1:0]);

  dmem_lane_align u_lane_align (
    .rdata_i    (mem.mem_rdata),
    .off_i      (off_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_o     (load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      wait_q      <= 8'd0;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      addr_q      <= 32'd0;
      be_q        <= 4'd0;
      wdata_q     <= 32'd0;
      off_q       <= 2'd0;
      size_q      <= SZ_BYTE;
      uns_q       <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      rdata_q     <= 32'd0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_valid_i) begin
            if (req_bad) begin
              state_q <= StResp;
              done_q  <= 1'b1;
              fault_q <= 1'b1;
              if (!req_we_i) rdata_q <= 32'd0;
            end else begin
              state_q     <= StBus;
              wait_q      <= 8'd0;
              mem_valid_q <= 1'b1;
              mem_we_q    <= req_we_i;
              addr_q      <= {req_addr_i[31:2], 2'b00};
              be_q        <= byte_enable(req_size_i, req_addr_i[1:0]);
              wdata_q     <= lane_wdata(req_size_i, req_wdata_i);
              off_q       <= req_addr_i[1:0];
              size_q      <= req_size_i;
              uns_q       <= req_unsigned_i;
            end
          end
        end
        StBus: begin
          if (mem.mem_ready) begin
            state_q     <= StResp;
            wait_q      <= 8'd0;
            mem_valid_q <= 1'b0;
            done_q      <= 1'b1;
            if (!mem_we_q) rdata_q <= load_data;
          end else if (wait_q == LastWait) begin
            state_q     <= StResp;
            mem_valid_q <= 1'b0;
            done_q      <= 1'b1;
            fault_q     <= 1'b1;
            if (!mem_we_q) rdata_q <= 32'd0;
          end else if (wait_q != 8'hFF) begin
            wait_q <= wait_q + 8'd1;
          end
        end
        StResp: begin
          // Core advances this cycle, so any still-visible req_valid is stale.
          state_q <= StIdle;
          done_q  <= 1'b0;
          fault_q <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign stall_o       = req_valid_i && (state_q != StResp);
  assign done_o        = done_q;
  assign fault_o       = fault_q;
  assign rdata_o       = rdata_q;
  assign mem.mem_valid = mem_valid_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_be    = be_q;
  assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: loads, stores, faults, timeout and reset mid-bus.
module tb_dmem_access_ctrl;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        done;
  logic        fault;
  logic [31:0] rdata;

  int n_tests = 0;
  int n_fail  = 0;

  dmem_access_ctrl_if bus ();

  dmem_access_ctrl #(
    .TIMEOUT (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid_i    (req_valid),
    .req_we_i       (req_we),
    .req_size_i     (req_size),
    .req_unsigned_i (req_unsigned),
    .req_addr_i     (req_addr),
    .req_wdata_i    (req_wdata),
    .stall_o        (stall),
    .done_o         (done),
    .fault_o        (fault),
    .rdata_o        (rdata),
    .mem            (bus.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // One access from request to done; ready is raised in bus cycle index `waits`.
  task automatic access(input string tag, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] bus_rdata, input int waits,
                        input logic [31:0] exp_addr, input logic [3:0] exp_be,
                        input logic [31:0] exp_wdata, input int exp_done_cyc,
                        input logic exp_fault, input logic [31:0] exp_rdata,
                        input int exp_valid_cyc);
    int  vcnt;
    bit  got_done;
    vcnt     = 0;
    got_done = 0;
    @(negedge clk);
    req_valid     = 1'b1;
    req_we        = we;
    req_size      = size;
    req_unsigned  = uns;
    req_addr      = addr;
    req_wdata     = wdata;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = bus_rdata;
    #1;
    check({tag, " stall c0"}, 32'(stall), 32'd1);
    for (int c = 1; c <= 300 && !got_done; c++) begin
      @(negedge clk);
      if (bus.mem_valid) begin
        vcnt++;
        check({tag, " addr"}, bus.mem_addr, exp_addr);
        check({tag, " be"}, 32'(bus.mem_be), 32'(exp_be));
        check({tag, " we"}, 32'(bus.mem_we), 32'(we));
        if (we) check({tag, " wdata"}, bus.mem_wdata, exp_wdata);
        check({tag, " stall bus"}, 32'(stall), 32'd1);
        bus.mem_ready = ((vcnt - 1) == waits);
      end else begin
        bus.mem_ready = 1'b0;
      end
      if (done) begin
        got_done = 1;
        check({tag, " done cycle"}, 32'(c), 32'(exp_done_cyc));
        check({tag, " fault"}, 32'(fault), 32'(exp_fault));
        check({tag, " rdata"}, rdata, exp_rdata);
        check({tag, " stall resp"}, 32'(stall), 32'd0);
        req_valid     = 1'b0;
        bus.mem_ready = 1'b0;
      end
    end
    if (!got_done) check({tag, " done seen"}, 32'd0, 32'd1);
    check({tag, " valid cycles"}, 32'(vcnt), 32'(exp_valid_cyc));
    @(negedge clk);
    check({tag, " done pulse"}, 32'(done), 32'd0);
    check({tag, " valid idle"}, 32'(bus.mem_valid), 32'd0);
  endtask

  initial begin
    rst_n         = 1'b0;
    req_valid     = 1'b0;
    req_we        = 1'b0;
    req_size      = SZ_WORD;
    req_unsigned  = 1'b0;
    req_addr      = 32'd0;
    req_wdata     = 32'd0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'd0;

    #12;
    check("rst valid", 32'(bus.mem_valid), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst fault", 32'(fault), 32'd0);
    check("rst rdata", rdata, 32'd0);
    check("rst be", 32'(bus.mem_be), 32'd0);
    check("rst stall idle", 32'(stall), 32'd0);
    req_valid = 1'b1;
    #1;
    check("rst stall follows req", 32'(stall), 32'd1);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    //     tag     we    size     uns   addr           wdata          bus_rdata     w
    access("lb",   1'b0, SZ_BYTE, 1'b0, 32'h0000_0103, 32'h0,         32'h80FF_0000, 0,
           32'h0000_0100, 4'b1000, 32'h0, 2, 1'b0, 32'hFFFF_FF80, 1);
    access("lhu",  1'b0, SZ_HALF, 1'b1, 32'h0000_0202, 32'h0,         32'hBEEF_1234, 0,
           32'h0000_0200, 4'b1100, 32'h0, 2, 1'b0, 32'h0000_BEEF, 1);
    access("sh",   1'b1, SZ_HALF, 1'b0, 32'h0000_0006, 32'h0000_A5C3, 32'hDEAD_DEAD, 3,
           32'h0000_0004, 4'b1100, 32'hA5C3_A5C3, 5, 1'b0, 32'h0000_BEEF, 4);
    access("mis",  1'b0, SZ_WORD, 1'b0, 32'h0000_0001, 32'h0,         32'h0,         0,
           32'h0, 4'b0000, 32'h0, 1, 1'b1, 32'h0000_0000, 0);
    access("lw",   1'b0, SZ_WORD, 1'b0, 32'h0000_0010, 32'h0,         32'h1234_5678, 0,
           32'h0000_0010, 4'b1111, 32'h0, 2, 1'b0, 32'h1234_5678, 1);
    access("ill",  1'b0, 2'b11,   1'b0, 32'h0000_0020, 32'h0,         32'h0,         0,
           32'h0, 4'b0000, 32'h0, 1, 1'b1, 32'h0000_0000, 0);
    access("lh",   1'b0, SZ_HALF, 1'b0, 32'h0000_0012, 32'h0,         32'h8001_0000, 1,
           32'h0000_0010, 4'b1100, 32'h0, 3, 1'b0, 32'hFFFF_8001, 2);
    access("tmo",  1'b0, SZ_BYTE, 1'b0, 32'h0000_0044, 32'h0,         32'h0,         999,
           32'h0000_0044, 4'b0001, 32'h0, 5, 1'b1, 32'h0000_0000, 4);
    access("sb",   1'b1, SZ_BYTE, 1'b0, 32'h0000_0009, 32'h0000_00E7, 32'h0,         0,
           32'h0000_0008, 4'b0010, 32'hE7E7_E7E7, 2, 1'b0, 32'h0000_0000, 1);
    access("lbu",  1'b0, SZ_BYTE, 1'b1, 32'h0000_0001, 32'h0,         32'h0000_AB00, 0,
           32'h0000_0000, 4'b0010, 32'h0, 2, 1'b0, 32'h0000_00AB, 1);

    // Reset in the middle of a stalled store.
    @(negedge clk);
    req_valid     = 1'b1;
    req_we        = 1'b1;
    req_size      = SZ_WORD;
    req_unsigned  = 1'b0;
    req_addr      = 32'h0000_0030;
    req_wdata     = 32'h1122_3344;
    bus.mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rmb valid before", 32'(bus.mem_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rmb valid async", 32'(bus.mem_valid), 32'd0);
    check("rmb we", 32'(bus.mem_we), 32'd0);
    check("rmb addr", bus.mem_addr, 32'd0);
    check("rmb be", 32'(bus.mem_be), 32'd0);
    check("rmb wdata", bus.mem_wdata, 32'd0);
    check("rmb rdata", rdata, 32'd0);
    check("rmb stall", 32'(stall), 32'd1);
    repeat (2) @(negedge clk);
    check("rmb done", 32'(done), 32'd0);
    check("rmb fault", 32'(fault), 32'd0);
    req_valid = 1'b0;
    rst_n     = 1'b1;
    access("post", 1'b0, SZ_WORD, 1'b0, 32'h0000_0010, 32'h0,         32'hA5A5_0F0F, 1,
           32'h0000_0010, 4'b1111, 32'h0, 3, 1'b0, 32'hA5A5_0F0F, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
